// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-dump frame streamer.
// Frame layout: header byte, 128 little-endian payload bytes, XOR checksum byte.
package regdump_pkg;

  localparam int unsigned REGDUMP_NUM_REGS    = 32;
  localparam int unsigned REGDUMP_REG_W       = 32;
  localparam int unsigned REGDUMP_BUS_W       = REGDUMP_NUM_REGS * REGDUMP_REG_W;
  localparam int unsigned REGDUMP_BYTE_W      = 8;
  localparam int unsigned REGDUMP_REG_IDX_W   = 5;
  localparam int unsigned REGDUMP_BYTE_IDX_W  = 2;
  localparam int unsigned REGDUMP_SEL_W       = REGDUMP_REG_IDX_W + REGDUMP_BYTE_IDX_W;
  localparam int unsigned REGDUMP_FRAME_LEN   = 130;
  localparam int unsigned REGDUMP_PAYLOAD_LEN = 128;

  localparam logic [REGDUMP_BYTE_W-1:0] REGDUMP_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECKSUM
  } regdump_state_e;

  // Payload byte at flat index {reg_idx, byte_idx}; register x0 always reads as zero.
  function automatic logic [REGDUMP_BYTE_W-1:0] regdump_byte(
    input logic [REGDUMP_BUS_W-1:0] snap,
    input logic [REGDUMP_SEL_W-1:0] sel
  );
    logic [REGDUMP_BYTE_W-1:0] b;
    b = snap[{sel, 3'b000} +: REGDUMP_BYTE_W];
    if (sel[REGDUMP_SEL_W-1:REGDUMP_BYTE_IDX_W] == '0) begin
      b = '0;
    end
    return b;
  endfunction

endpackage

// File: rtl/regdump_streamer_if.sv
// Byte stream with valid/ready handshake carrying the register-dump frame.
interface regdump_streamer_if;
  import regdump_pkg::*;

  logic [REGDUMP_BYTE_W-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/regdump_streamer.sv
// Snapshots the 32x32 debug register bus on request and streams it out as a
// framed byte sequence (header, payload, XOR checksum) over valid/ready.
module regdump_streamer
  import regdump_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dump_req,
  input  logic [REGDUMP_BUS_W-1:0] dbg_reg_data,
  regdump_streamer_if.master       tx,
  output logic                     busy,
  output logic                     done
);

  regdump_state_e state_q, state_d;

  logic [REGDUMP_BUS_W-1:0]      snap_q;
  logic [REGDUMP_REG_IDX_W-1:0]  reg_idx_q, reg_idx_d;
  logic [REGDUMP_BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [REGDUMP_BYTE_W-1:0]     csum_q, csum_d;
  logic [REGDUMP_BYTE_W-1:0]     tx_data_q, tx_data_d;
  logic                          tx_valid_q, tx_valid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          capture_c;
  logic                          hs_c;
  logic [REGDUMP_SEL_W-1:0]      sel_c;
  logic [REGDUMP_SEL_W-1:0]      sel_nxt_c;

  assign hs_c      = tx_valid_q & tx.tx_ready;
  assign sel_c     = {reg_idx_q, byte_idx_q};
  assign sel_nxt_c = sel_c + REGDUMP_SEL_W'(1);

  // Next-state, next-output and counter updates.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    capture_c  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (dump_req) begin
          capture_c  = 1'b1;
          state_d    = HEADER;
          reg_idx_d  = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          tx_data_d  = REGDUMP_HEADER;
          tx_valid_d = 1'b1;
        end
      end

      HEADER: begin
        if (hs_c) begin
          state_d   = PAYLOAD;
          tx_data_d = regdump_byte(snap_q, sel_c);
        end
      end

      PAYLOAD: begin
        if (hs_c) begin
          csum_d                  = csum_q ^ tx_data_q;
          {reg_idx_d, byte_idx_d} = sel_nxt_c;
          if (sel_c == REGDUMP_SEL_W'(REGDUMP_PAYLOAD_LEN - 1)) begin
            state_d   = CHECKSUM;
            tx_data_d = csum_q ^ tx_data_q;
          end else begin
            tx_data_d = regdump_byte(snap_q, sel_nxt_c);
          end
        end
      end

      CHECKSUM: begin
        if (hs_c) begin
          state_d    = IDLE;
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Frame snapshot; later bus changes cannot reach a frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (capture_c) begin
      snap_q <= dbg_reg_data;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_regdump_streamer.sv
// Randomized bench for regdump_streamer: accepted bytes are compared with a
// frame built from the register values by a simple queue-based model.
module tb_regdump_streamer;
  import regdump_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_req;
  logic [1023:0] dbg_reg_data;
  logic        busy;
  logic        done;

  regdump_streamer_if tx_if();

  regdump_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .dump_req     (dump_req),
    .dbg_reg_data (dbg_reg_data),
    .tx           (tx_if.master),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: register values and the frame they should produce.
  logic [31:0] regs [32];
  logic [7:0]  exp_q [$];

  task automatic build_exp();
    logic [7:0] cs;
    logic [31:0] v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int r = 0; r < 32; r++) begin
      v = (r == 0) ? 32'h0 : regs[r];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(8'((v >> (8 * b)) & 32'hFF));
        cs = cs ^ 8'((v >> (8 * b)) & 32'hFF);
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic drive_bus();
    for (int r = 0; r < 32; r++) dbg_reg_data[32*r +: 32] = regs[r];
  endtask

  // Ready driver: constant high or roughly 50% random duty.
  bit rand_ready = 1'b0;
  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_if.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor sampled on the falling edge.
  logic [7:0] rx_q [$];
  int hs_cyc_q [$];
  int done_cyc_q [$];
  int cyc = 0;
  int last_hs_cyc = -10;
  int valid_cycles = 0;
  int done_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (prev_valid && !prev_hs) begin
          check("stall_valid", 32'(tx_if.tx_valid), 32'(1'b1));
          check("stall_data", 32'(tx_if.tx_data), 32'(prev_data));
        end
        if (done) begin
          done_cnt++;
          done_cyc_q.push_back(cyc);
          check("done_after_cs", 32'(cyc - last_hs_cyc), 32'(1));
          check("busy_with_done", 32'(busy), 32'(0));
          check("valid_in_idle", 32'(tx_if.tx_valid), 32'(0));
        end
        if (tx_if.tx_valid) valid_cycles++;
        prev_valid = tx_if.tx_valid;
        prev_data  = tx_if.tx_data;
        prev_hs    = tx_if.tx_valid & tx_if.tx_ready;
        if (prev_hs) begin
          rx_q.push_back(tx_if.tx_data);
          hs_cyc_q.push_back(cyc);
          last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic reset_mon();
    rx_q.delete();
    hs_cyc_q.delete();
    done_cyc_q.delete();
    valid_cycles = 0;
    done_cnt = 0;
  endtask

  // Called just after a rising edge; checks header latency of one cycle.
  task automatic start_frame();
    dump_req = 1'b1;
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    check("hdr_valid", 32'(tx_if.tx_valid), 32'(1));
    check("hdr_data", 32'(tx_if.tx_data), 32'(8'hA5));
    check("hdr_busy", 32'(busy), 32'(1));
  endtask

  task automatic wait_bytes(input int n, input int pulse_at, input int budget);
    bit pulsed = 1'b0;
    bit pulse_on = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() >= n) break;
      @(posedge clk);
      #1;
      if (pulse_on) begin
        dump_req = 1'b0;
        pulse_on = 1'b0;
      end
      if (pulse_at >= 0 && !pulsed && rx_q.size() >= pulse_at) begin
        dump_req = 1'b1;
        pulsed   = 1'b1;
        pulse_on = 1'b1;
      end
    end
    if (pulse_on) dump_req = 1'b0;
    check("byte_budget", 32'(rx_q.size() >= n), 32'(1));
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare_frame(input int base, input string tag);
    int nbad = 0;
    for (int i = 0; i < 130; i++) begin
      if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) nbad++;
    end
    check(tag, 32'(nbad), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    dump_req = 1'b0;
    dbg_reg_data = '0;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    @(posedge clk);
    #2;
    check("rst_valid", 32'(tx_if.tx_valid), 32'(0));
    check("rst_data", 32'(tx_if.tx_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle(2);

    // 1: all-zero registers, ready held high.
    build_exp();
    drive_bus();
    reset_mon();
    start_frame();
    wait_bytes(130, -1, 400);
    settle(3);
    compare_frame(0, "t1_frame");
    check("t1_valid_cycles", 32'(valid_cycles), 32'(130));
    check("t1_done_cnt", 32'(done_cnt), 32'(1));
    check("t1_busy_idle", 32'(busy), 32'(0));
    if (hs_cyc_q.size() == 130) check("t1_no_bubble", 32'(hs_cyc_q[129] - hs_cyc_q[0]), 32'(129));

    // 2: directed values with x0 forced to zero.
    regs[0] = 32'hFFFF_FFFF;
    regs[1] = 32'h1122_3344;
    regs[31] = 32'hDEAD_BEEF;
    build_exp();
    drive_bus();
    reset_mon();
    start_frame();
    wait_bytes(130, -1, 400);
    settle(3);
    compare_frame(0, "t2_frame");
    if (rx_q.size() >= 130) begin
      check("t2_x0", {rx_q[1], rx_q[2], rx_q[3], rx_q[4]}, 32'h0000_0000);
      check("t2_x1", {rx_q[5], rx_q[6], rx_q[7], rx_q[8]}, 32'h4433_2211);
      check("t2_x31", {rx_q[125], rx_q[126], rx_q[127], rx_q[128]}, 32'hEFBE_ADDE);
      check("t2_checksum", 32'(rx_q[129]), 32'h66);
    end
    check("t2_done_cnt", 32'(done_cnt), 32'(1));

    // 3: same data under random backpressure.
    rand_ready = 1'b1;
    reset_mon();
    start_frame();
    wait_bytes(130, -1, 2000);
    settle(3);
    compare_frame(0, "t3_frame");
    check("t3_done_cnt", 32'(done_cnt), 32'(1));

    // 4: random register contents; bus changes after capture, extra request mid-frame.
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[1] = 32'h1122_3344;
    build_exp();
    drive_bus();
    reset_mon();
    start_frame();
    dbg_reg_data[63:32] = 32'hCAFE_BABE;
    dbg_reg_data[32*7 +: 32] = ~regs[7];
    wait_bytes(130, 40, 2000);
    settle(3);
    compare_frame(0, "t4_frame");
    if (rx_q.size() >= 9) check("t4_x1", {rx_q[5], rx_q[6], rx_q[7], rx_q[8]}, 32'h4433_2211);
    settle(20);
    check("t4_no_new_frame", 32'(rx_q.size()), 32'(130));
    check("t4_done_cnt", 32'(done_cnt), 32'(1));
    check("t4_idle_busy", 32'(busy), 32'(0));

    // 5: reset in the middle of the payload.
    rand_ready = 1'b0;
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    build_exp();
    drive_bus();
    reset_mon();
    start_frame();
    wait_bytes(60, -1, 400);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(tx_if.tx_valid), 32'(0));
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_done", 32'(done), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle(2);
    check("t5_partial_no_done", 32'(done_cnt), 32'(0));
    reset_mon();
    start_frame();
    wait_bytes(130, -1, 400);
    settle(3);
    compare_frame(0, "t5_frame");
    if (rx_q.size() > 0) check("t5_header", 32'(rx_q[0]), 32'(8'hA5));
    check("t5_done_cnt", 32'(done_cnt), 32'(1));

    // 6: request held high gives back-to-back frames.
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    build_exp();
    drive_bus();
    reset_mon();
    dump_req = 1'b1;
    wait_bytes(260, -1, 800);
    dump_req = 1'b0;
    settle(5);
    compare_frame(0, "t6_frame1");
    compare_frame(130, "t6_frame2");
    check("t6_len", 32'(rx_q.size()), 32'(260));
    check("t6_done_cnt", 32'(done_cnt), 32'(2));
    if (hs_cyc_q.size() >= 131 && done_cyc_q.size() >= 1)
      check("t6_hdr_after_done", 32'(hs_cyc_q[130] - done_cyc_q[0]), 32'(1));
    else
      check("t6_hdr_after_done", 32'(hs_cyc_q.size()), 32'(260));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
